// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the Execute-stage ALU sequencer.
//   - ifun encodings accepted on the request channel
//   - sequencer state enum
//   - condition-code bit positions and reset value ({OF,SF,ZF})
package alu_pkg;

   localparam logic [3:0] FUN_ADD = 4'd0;
   localparam logic [3:0] FUN_SUB = 4'd1;
   localparam logic [3:0] FUN_AND = 4'd2;
   localparam logic [3:0] FUN_XOR = 4'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NEG  = 2'd1,
      EXEC = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam int CC_ZF = 0;
   localparam int CC_SF = 1;
   localparam int CC_OF = 2;

   localparam logic [2:0] CC_RST_VAL = 3'b001;

endpackage

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: sequences one ALU op per request through the shared
// ripple adder (carry-in tied 0), owns the condition-code register and
// returns the result on a valid/ready response channel.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_fun/req_a/req_b        ifun and operands
//   req_set_cc                 write cc when the op completes
//   rsp_valid/rsp_ready        response handshake
//   rsp_result/rsp_err         result, illegal-ifun flag
//   cc                         {OF,SF,ZF}
//   add_a/add_b                shared adder operands (0 when unused)
//   add_out/add_cf             shared adder sum and {OF,SF,ZF}
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a request; adder idle
// NEG   | SUB only: adder forms ~b + 1
// EXEC  | adder (or local logic) forms the result; registered on exit
// RESP  | response held until rsp_ready
module alu_seq_ctrl
   import alu_pkg::*;
#(
   parameter int         W      = 64,
   parameter logic [2:0] CC_RST = CC_RST_VAL
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [3:0]   req_fun,
   input  logic [W-1:0] req_a,
   input  logic [W-1:0] req_b,
   input  logic         req_set_cc,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_result,
   output logic         rsp_err,
   output logic [2:0]   cc,
   output logic [W-1:0] add_a,
   output logic [W-1:0] add_b,
   input  logic [W-1:0] add_out,
   input  logic [2:0]   add_cf
);

   state_t         state;
   logic [3:0]     fun_q;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic           set_cc_q;

   logic [W-1:0]   exec_res;
   logic [2:0]     exec_flags;
   logic           exec_err;

   // Result and flags as seen during EXEC.
   always_comb begin
      exec_res   = '0;
      exec_flags = '0;
      exec_err   = 1'b0;
      case (fun_q)
         FUN_ADD: begin
            exec_res   = add_out;
            exec_flags = add_cf;
         end
         FUN_SUB: begin
            exec_res          = add_out;
            exec_flags[CC_ZF] = add_cf[CC_ZF];
            exec_flags[CC_SF] = add_cf[CC_SF];
            // The adder's OF is wrong when b is the most negative value
            // (its negation wraps), so derive OF from the a - b signs.
            exec_flags[CC_OF] = (a_q[W-1] != b_q[W-1]) && (add_out[W-1] != a_q[W-1]);
         end
         FUN_AND, FUN_XOR: begin
            exec_res          = (fun_q == FUN_AND) ? (a_q & b_q) : (a_q ^ b_q);
            exec_flags[CC_ZF] = (exec_res == '0);
            exec_flags[CC_SF] = exec_res[W-1];
         end
         default: exec_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_err    <= 1'b0;
         rsp_result <= '0;
         cc         <= CC_RST;
         add_a      <= '0;
         add_b      <= '0;
         fun_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         set_cc_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  fun_q     <= req_fun;
                  a_q       <= req_a;
                  b_q       <= req_b;
                  set_cc_q  <= req_set_cc;
                  req_ready <= 1'b0;
                  if (req_fun == FUN_SUB) begin
                     state <= NEG;
                     add_a <= ~req_b;
                     add_b <= {{(W-1){1'b0}}, 1'b1};
                  end else begin
                     state <= EXEC;
                     if (req_fun == FUN_ADD) begin
                        add_a <= req_a;
                        add_b <= req_b;
                     end else begin
                        add_a <= '0;
                        add_b <= '0;
                     end
                  end
               end
            end
            NEG: begin
               // add_b doubles as the negated-b register for the add pass.
               add_a <= a_q;
               add_b <= add_out;
               state <= EXEC;
            end
            EXEC: begin
               rsp_result <= exec_res;
               rsp_err    <= exec_err;
               rsp_valid  <= 1'b1;
               if (set_cc_q && !exec_err) begin
                  cc <= exec_flags;
               end
               add_a <= '0;
               add_b <= '0;
               state <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
